// File: rtl/stumps_bist_ctrl.sv
// stumps_bist_ctrl: sequencer for the STUMPS logic-BIST datapath.
// Steps SRSG, scan chains and MISR through LOAD / SHIFT / CAPTURE / FLUSH / DONE
// for a programmed number of patterns. Every output is a registered Moore output.
// Optional feature macro: STUMPS_BIST_PAUSE_EN adds a 'pause' input that freezes
// SHIFT and FLUSH and gates srsg_en/scan_en/misr_en while it is sampled high.
// Handshake: start is a level sampled only in IDLE; abort is a synchronous
// level that wins over start and pause in every state; done is a one-cycle pulse.
module stumps_bist_ctrl #(
   parameter int SRSG_SIZE = 32,
   parameter int CHAIN_LEN = 16,
   parameter int PAT_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 internalRst,
   input  logic                 start,
   input  logic                 abort,
`ifdef STUMPS_BIST_PAUSE_EN
   input  logic                 pause,
`endif
   input  logic [PAT_CNT_W-1:0] pat_count,
   input  logic [SRSG_SIZE-1:0] poly_in,
   input  logic [SRSG_SIZE-1:0] seed_in,
   output logic [SRSG_SIZE-1:0] srsg_poly,
   output logic [SRSG_SIZE-1:0] srsg_seed,
   output logic                 srsg_en,
   output logic                 scan_en,
   output logic                 capture,
   output logic                 misr_en,
   output logic                 busy,
   output logic                 done,
   output logic [PAT_CNT_W-1:0] pat_idx
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      FLUSH   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [PAT_CNT_W-1:0]   total_q, total_d;
   logic [PAT_CNT_W-1:0]   pat_idx_d;
   logic [SRSG_SIZE-1:0]   poly_d, seed_d;
   logic                   hold;
   logic                   run_d;
   logic                   srsg_en_d, scan_en_d, capture_d, misr_en_d, busy_d, done_d;

   // A sampled pause suspends the next SHIFT/FLUSH cycle; it never stretches other states.
`ifdef STUMPS_BIST_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // Next-state, counter and latch logic. In SHIFT/FLUSH the registered scan_en
   // marks the current cycle as a real shift, so paused cycles do not advance cnt.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      pat_idx_d = pat_idx;
      poly_d    = srsg_poly;
      seed_d    = srsg_seed;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  total_d   = pat_count;
                  poly_d    = poly_in;
                  seed_d    = seed_in;
                  pat_idx_d = '0;
                  cnt_d     = '0;
                  state_d   = (pat_count == '0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               if (scan_en) begin
                  if (cnt_q == LAST_SHIFT) begin
                     cnt_d   = '0;
                     state_d = CAPTURE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            CAPTURE: begin
               // pat_idx < total here, so the increment cannot wrap.
               pat_idx_d = pat_idx + PAT_CNT_W'(1);
               cnt_d     = '0;
               state_d   = (pat_idx_d == total_q) ? FLUSH : SHIFT;
            end
            FLUSH: begin
               if (scan_en) begin
                  if (cnt_q == LAST_SHIFT) begin
                     cnt_d   = '0;
                     state_d = DONE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state, registered below so outputs are pure Moore.
   always_comb begin
      run_d     = ((state_d == SHIFT) || (state_d == FLUSH)) && !hold;
      srsg_en_d = run_d && (state_d == SHIFT);
      scan_en_d = run_d;
      misr_en_d = run_d && ((state_d == FLUSH) || (pat_idx_d != '0));
      capture_d = (state_d == CAPTURE);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
   end

   // State, counters, latched run configuration and output registers.
   always_ff @(posedge clk or posedge internalRst) begin
      if (internalRst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         total_q   <= '0;
         pat_idx   <= '0;
         srsg_poly <= '0;
         srsg_seed <= '0;
         srsg_en   <= 1'b0;
         scan_en   <= 1'b0;
         capture   <= 1'b0;
         misr_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         total_q   <= total_d;
         pat_idx   <= pat_idx_d;
         srsg_poly <= poly_d;
         srsg_seed <= seed_d;
         srsg_en   <= srsg_en_d;
         scan_en   <= scan_en_d;
         capture   <= capture_d;
         misr_en   <= misr_en_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// tb_stumps_bist_ctrl: self-checking bench for stumps_bist_ctrl.
// Expected per-cycle outputs come from a trace model that lists each run as
// LOAD, then per pattern CHAIN_LEN shift cycles plus one capture, then the flush
// and the done cycle.
module tb_stumps_bist_ctrl;

   localparam int SW = 32;
   localparam int CL = 4;
   localparam int PW = 8;
   localparam int EW = PW + 6;

   logic          clk = 1'b0;
   logic          internalRst;
   logic          start;
   logic          abort;
`ifdef STUMPS_BIST_PAUSE_EN
   logic          pause;
`endif
   logic [PW-1:0] pat_count;
   logic [SW-1:0] poly_in, seed_in;
   logic [SW-1:0] srsg_poly, srsg_seed;
   logic          srsg_en, scan_en, capture, misr_en, busy, done;
   logic [PW-1:0] pat_idx;
   logic [EW-1:0] obs;

   logic [EW-1:0] exp_q[$];
   int            checks   = 0;
   int            failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   stumps_bist_ctrl #(
      .SRSG_SIZE(SW),
      .CHAIN_LEN(CL),
      .PAT_CNT_W(PW)
   ) dut (
      .clk        (clk),
      .internalRst(internalRst),
      .start      (start),
      .abort      (abort),
`ifdef STUMPS_BIST_PAUSE_EN
      .pause      (pause),
`endif
      .pat_count  (pat_count),
      .poly_in    (poly_in),
      .seed_in    (seed_in),
      .srsg_poly  (srsg_poly),
      .srsg_seed  (srsg_seed),
      .srsg_en    (srsg_en),
      .scan_en    (scan_en),
      .capture    (capture),
      .misr_en    (misr_en),
      .busy       (busy),
      .done       (done),
      .pat_idx    (pat_idx)
   );

   assign obs = {pat_idx, busy, done, capture, misr_en, scan_en, srsg_en};

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] mk(input int p, input bit b, input bit d, input bit c,
                                        input bit m, input bit s, input bit g);
      return {PW'(p), b, d, c, m, s, g};
   endfunction

   // Per-cycle expected outputs of one complete run of n patterns.
   task automatic build_trace(input int n);
      exp_q.delete();
      if (n == 0) begin
         exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
         return;
      end
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < CL; c++) exp_q.push_back(mk(p, 1, 0, 0, (p != 0), 1, 1));
         exp_q.push_back(mk(p, 1, 0, 1, 0, 0, 0));
      end
      for (int c = 0; c < CL; c++) exp_q.push_back(mk(n, 1, 0, 0, 1, 1, 0));
      exp_q.push_back(mk(n, 1, 1, 0, 0, 0, 0));
   endtask

   // ---------------- driver ----------------
   // Entered at a negedge during IDLE; returns at the negedge of the IDLE cycle after the run.
   task automatic run(input int n, input logic [SW-1:0] poly, input logic [SW-1:0] seed,
                      input int abort_at, input bit hold);
      logic [EW-1:0] e;
      int            last_p;
      int            i;
      build_trace(n);
      start     = 1'b1;
      pat_count = PW'(n);
      poly_in   = poly;
      seed_in   = seed;
      @(negedge clk);
      start  = hold;
      if (!hold) begin
         pat_count = PW'($urandom_range(0, 255));
         poly_in   = $urandom;
         seed_in   = $urandom;
      end
      last_p = 0;
      i      = 0;
      while (exp_q.size() > 0) begin
         e      = exp_q.pop_front();
         last_p = int'(e[EW-1:6]);
         check("trace", 64'(obs), 64'(e));
         check("poly", 64'(srsg_poly), 64'(poly));
         check("seed", 64'(srsg_seed), 64'(seed));
         if (i == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            break;
         end
         i++;
         @(negedge clk);
      end
      check("idle_after", 64'(obs), 64'(mk(last_p, 0, 0, 0, 0, 0, 0)));
      check("poly_hold", 64'(srsg_poly), 64'(poly));
      check("seed_hold", 64'(srsg_seed), 64'(seed));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int ab;
      int dones;
      bit ended;
      internalRst = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
`ifdef STUMPS_BIST_PAUSE_EN
      pause       = 1'b0;
`endif
      pat_count   = '0;
      poly_in     = '0;
      seed_in     = '0;
      repeat (3) @(negedge clk);
      check("reset_out", 64'(obs), 64'(0));
      check("reset_poly", 64'(srsg_poly), 64'(0));
      check("reset_seed", 64'(srsg_seed), 64'(0));
      internalRst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", 64'(obs), 64'(0));

      // Reference run: 2 patterns with the documented polynomial and seed.
      run(2, 32'h8020_0003, 32'h0000_0001, -1, 1'b0);
      // Zero patterns go straight to DONE.
      run(0, 32'h1234_5678, 32'h9abc_def0, -1, 1'b0);
      run(1, 32'hdead_beef, 32'h0bad_f00d, -1, 1'b0);

      // Abort in the second SHIFT of a 5-pattern run, then restart right away.
      run(5, 32'h0f0f_0f0f, 32'hf0f0_f0f0, 7, 1'b0);
      run(1, 32'h1111_2222, 32'h3333_4444, -1, 1'b0);

      // start and abort together in IDLE: nothing begins.
      start = 1'b1;
      abort = 1'b1;
      pat_count = 8'd3;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", 64'(busy), 64'(0));
      @(negedge clk);
      check("start_abort_idle", 64'(obs), 64'(mk(1, 0, 0, 0, 0, 0, 0)));

      // start held high: one run per acceptance, re-accepted right after DONE.
      run(2, 32'h5555_aaaa, 32'h0000_00ff, -1, 1'b1);
      @(negedge clk);
      check("reaccept_load", 64'(obs), 64'(mk(0, 1, 0, 0, 0, 0, 0)));
      start = 1'b0;
      dones = 0;
      ended = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (!busy) begin
            ended = 1'b1;
            break;
         end
      end
      check("reaccept_end", 64'(ended), 64'(1));
      check("reaccept_dones", 64'(dones), 64'(1));
      repeat (5) @(negedge clk);
      check("no_extra_run", 64'(busy), 64'(0));

      // Largest legal pattern count.
      run(255, 32'hcafe_babe, 32'h0000_0007, -1, 1'b0);

      // Randomized runs, some aborted at a random point.
      for (int r = 0; r < 12; r++) begin
         n  = $urandom_range(0, 6);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + n * (CL + 1) + CL) : -1;
         run(n, $urandom, $urandom, ab, 1'b0);
      end

      // Asynchronous reset in the middle of a run.
      start     = 1'b1;
      pat_count = 8'd3;
      poly_in   = 32'h7777_8888;
      seed_in   = 32'h9999_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 internalRst = 1'b1;
      #1;
      check("async_rst_out", 64'(obs), 64'(0));
      check("async_rst_poly", 64'(srsg_poly), 64'(0));
      check("async_rst_seed", 64'(srsg_seed), 64'(0));
      @(negedge clk);
      internalRst = 1'b0;
      @(negedge clk);
      check("after_rst_idle", 64'(obs), 64'(0));
      run(2, 32'h0101_0101, 32'h0202_0202, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
